// File: rtl/ad9054a_if.sv
// ---------------------------------------------------------------------------
// axistream_if: minimal AXI-Stream channel without back-pressure.
//
// Ports:
//   aclk   - stream clock; carried with the bundle so a sink can use it
// Signals:
//   tdata  - 16-bit data word
//   tvalid - one-cycle qualifier for tdata; the sink must accept every beat
// Modports:
//   master - drives tdata/tvalid
//   slave  - observes tdata/tvalid
// ---------------------------------------------------------------------------
interface axistream_if (
    input logic aclk
);
    logic [15:0] tdata;
    logic        tvalid;

    modport master (
        input  aclk,
        output tdata,
        output tvalid
    );

    modport slave (
        input aclk,
        input tdata,
        input tvalid
    );
endinterface : axistream_if

// File: rtl/ad9054a.sv
// ---------------------------------------------------------------------------
// ad9054a: capture controller for an AD9054A 8-bit ADC.
//
// Derives the converter's encode clock and DS sync strobe from clkin, samples
// the two ADC output buses on every encode falling edge and presents the
// packed samples as 16-bit words on an AXI-Stream master (no tready).
//
// Parameters:
//   ENC_HALF   - clkin cycles per encode half-period (>= 1)
//   DEMUX_MODE - 0: interleaved A/B pairs, 1: single-bus (port A only)
//
// Ports:
//   clkin       in   system clock (only clock)
//   rstn        in   asynchronous active-low reset
//   da, db      in   ADC output buses A and B
//   encode      out  ADC encode clock (flop)
//   encode_b    out  complement of encode
//   ds          out  ADC data-sync strobe, active high (flop)
//   ds_b        out  complement of ds
//   demux       out  constant DEMUX_MODE
//   m_axis_aclk out  stream clock, same net as clkin
//   m_axis      axistream_if.master: tdata[15:0], tvalid
// ---------------------------------------------------------------------------
module ad9054a #(
    parameter int ENC_HALF   = 1,
    parameter int DEMUX_MODE = 0
) (
    input  logic              clkin,
    input  logic              rstn,
    input  logic [7:0]        da,
    input  logic [7:0]        db,
    output logic              encode,
    output logic              encode_b,
    output logic              ds,
    output logic              ds_b,
    output logic              demux,
    output logic              m_axis_aclk,
    axistream_if.master       m_axis
);
    localparam int DATA_W = 8;
    localparam int CNT_W  = (ENC_HALF > 1) ? $clog2(ENC_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENC_HALF - 1);

    logic [CNT_W-1:0]    div_cnt;
    logic                div_wrap;
    logic                enc_fall;
    logic                phase;      // LSB of the sample index n
    logic                emit;
    logic                vld_p0;
    logic [2*DATA_W-1:0] tdata_p0;

    assign div_wrap = (div_cnt == CNT_LAST);
    // encode is about to go 1->0 on this edge: the ADC outputs are settled
    // because the converter only updates them on encode rising edges.
    assign enc_fall = div_wrap && encode;

    // Interleaved mode keeps odd samples only, so the n=0 sample taken while
    // ds is still active never starts a pair.
    assign emit = enc_fall && ((DEMUX_MODE != 0) || phase);

    // ---- encode divider and DS sequencing ----
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            encode  <= 1'b0;
            ds      <= 1'b1;
            phase   <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                encode  <= ~encode;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (enc_fall) begin
                ds    <= 1'b0;
                phase <= ~phase;
            end
        end
    end

    // ---- capture stage: bus sample and stream word on the same edge ----
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            vld_p0   <= 1'b0;
            tdata_p0 <= '0;
        end else begin
            vld_p0 <= emit;
            if (emit) begin
                if (DEMUX_MODE != 0) begin
                    tdata_p0 <= {{DATA_W{1'b0}}, da};
                end else begin
                    tdata_p0 <= {db, da};
                end
            end
        end
    end

    assign encode_b      = ~encode;
    assign ds_b          = ~ds;
    assign demux         = (DEMUX_MODE != 0);
    assign m_axis_aclk   = clkin;
    assign m_axis.tdata  = tdata_p0;
    assign m_axis.tvalid = vld_p0;

endmodule : ad9054a

// File: tb/tb_ad9054a.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ad9054a: directed, table-driven bench for ad9054a.
//   u0: ENC_HALF=1, DEMUX_MODE=0 (interleaved)
//   u1: ENC_HALF=1, DEMUX_MODE=1 (single bus)
//   u2: ENC_HALF=3, DEMUX_MODE=0
// All three share clkin and rstn.
// ---------------------------------------------------------------------------
module tb_ad9054a;
    logic clkin = 1'b0;
    logic rstn  = 1'b0;

    logic [7:0] da0, db0, da1, db1, da2, db2;
    logic enc0, encb0, ds0, dsb0, dmx0, ack0;
    logic enc1, encb1, ds1, dsb1, dmx1, ack1;
    logic enc2, encb2, ds2, dsb2, dmx2, ack2;

    int checks = 0;
    int errors = 0;

    always #12.5 clkin = ~clkin;

    axistream_if ax0 (.aclk(clkin));
    axistream_if ax1 (.aclk(clkin));
    axistream_if ax2 (.aclk(clkin));

    ad9054a #(.ENC_HALF(1), .DEMUX_MODE(0)) u0 (
        .clkin(clkin), .rstn(rstn), .da(da0), .db(db0),
        .encode(enc0), .encode_b(encb0), .ds(ds0), .ds_b(dsb0),
        .demux(dmx0), .m_axis_aclk(ack0), .m_axis(ax0.master));

    ad9054a #(.ENC_HALF(1), .DEMUX_MODE(1)) u1 (
        .clkin(clkin), .rstn(rstn), .da(da1), .db(db1),
        .encode(enc1), .encode_b(encb1), .ds(ds1), .ds_b(dsb1),
        .demux(dmx1), .m_axis_aclk(ack1), .m_axis(ax1.master));

    ad9054a #(.ENC_HALF(3), .DEMUX_MODE(0)) u2 (
        .clkin(clkin), .rstn(rstn), .da(da2), .db(db2),
        .encode(enc2), .encode_b(encb2), .ds(ds2), .ds_b(dsb2),
        .demux(dmx2), .m_axis_aclk(ack2), .m_axis(ax2.master));

    typedef struct {
        logic [7:0]  da0, db0, da1;
        logic        enc0, ds0, vld0;
        logic [15:0] td0;
        logic        vld1;
        logic [15:0] td1;
        logic        enc2, vld2;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " enc0"},  {15'd0, enc0},  16'd0);
        chk({tag, " encb0"}, {15'd0, encb0}, 16'd1);
        chk({tag, " ds0"},   {15'd0, ds0},   16'd1);
        chk({tag, " dsb0"},  {15'd0, dsb0},  16'd0);
        chk({tag, " vld0"},  {15'd0, ax0.tvalid}, 16'd0);
        chk({tag, " td0"},   ax0.tdata, 16'd0);
        chk({tag, " vld1"},  {15'd0, ax1.tvalid}, 16'd0);
        chk({tag, " td1"},   ax1.tdata, 16'd0);
        chk({tag, " enc2"},  {15'd0, enc2},  16'd0);
        chk({tag, " ds2"},   {15'd0, ds2},   16'd1);
    endtask

    // Runaway guard
    initial begin
        #40000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        // edge k (1-based after release): inputs present at edge k, outputs after edge k
        tbl[0]  = '{8'h0A, 8'h0F, 8'h41, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{8'h0A, 8'h1A, 8'h42, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b0, 1'b0};
        tbl[2]  = '{8'h0A, 8'h1A, 8'h43, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0042, 1'b1, 1'b0};
        tbl[3]  = '{8'h12, 8'h1A, 8'h44, 1'b0, 1'b0, 1'b1, 16'h1A12, 1'b1, 16'h0044, 1'b1, 1'b0};
        tbl[4]  = '{8'h12, 8'h1A, 8'h45, 1'b1, 1'b0, 1'b0, 16'h1A12, 1'b0, 16'h0044, 1'b1, 1'b0};
        tbl[5]  = '{8'h12, 8'h24, 8'h46, 1'b0, 1'b0, 1'b0, 16'h1A12, 1'b1, 16'h0046, 1'b0, 1'b0};
        tbl[6]  = '{8'h12, 8'h24, 8'h47, 1'b1, 1'b0, 1'b0, 16'h1A12, 1'b0, 16'h0046, 1'b0, 1'b0};
        tbl[7]  = '{8'h1C, 8'h24, 8'h48, 1'b0, 1'b0, 1'b1, 16'h241C, 1'b1, 16'h0048, 1'b0, 1'b0};
        tbl[8]  = '{8'h1C, 8'h24, 8'h49, 1'b1, 1'b0, 1'b0, 16'h241C, 1'b0, 16'h0048, 1'b1, 1'b0};
        tbl[9]  = '{8'h1C, 8'h2E, 8'h4A, 1'b0, 1'b0, 1'b0, 16'h241C, 1'b1, 16'h004A, 1'b1, 1'b0};
        tbl[10] = '{8'h1C, 8'h2E, 8'h4B, 1'b1, 1'b0, 1'b0, 16'h241C, 1'b0, 16'h004A, 1'b1, 1'b0};
        tbl[11] = '{8'h26, 8'h2E, 8'h4C, 1'b0, 1'b0, 1'b1, 16'h2E26, 1'b1, 16'h004C, 1'b0, 1'b1};

        da0 = 8'h0A; db0 = 8'h0F;
        da1 = 8'h00; db1 = 8'hFF;
        da2 = 8'h55; db2 = 8'hAA;

        // ---- reset held for 830 ns ----
        for (int i = 0; i < 4; i++) begin
            #200;
            chk_reset_state("reset");
        end
        chk("demux0", {15'd0, dmx0}, 16'd0);
        chk("demux1", {15'd0, dmx1}, 16'd1);
        #30;
        @(negedge clkin);
        da0 = tbl[0].da0; db0 = tbl[0].db0; da1 = tbl[0].da1;
        rstn = 1'b1;

        // ---- table: edges 1..12 after release ----
        for (int i = 0; i < 12; i++) begin
            @(posedge clkin);
            @(negedge clkin);
            chk($sformatf("e%0d enc0", i + 1), {15'd0, enc0}, {15'd0, tbl[i].enc0});
            chk($sformatf("e%0d encb0", i + 1), {15'd0, encb0}, {15'd0, ~tbl[i].enc0});
            chk($sformatf("e%0d ds0", i + 1), {15'd0, ds0}, {15'd0, tbl[i].ds0});
            chk($sformatf("e%0d dsb0", i + 1), {15'd0, dsb0}, {15'd0, ~tbl[i].ds0});
            chk($sformatf("e%0d vld0", i + 1), {15'd0, ax0.tvalid}, {15'd0, tbl[i].vld0});
            chk($sformatf("e%0d td0", i + 1), ax0.tdata, tbl[i].td0);
            chk($sformatf("e%0d vld1", i + 1), {15'd0, ax1.tvalid}, {15'd0, tbl[i].vld1});
            chk($sformatf("e%0d td1", i + 1), ax1.tdata, tbl[i].td1);
            chk($sformatf("e%0d enc2", i + 1), {15'd0, enc2}, {15'd0, tbl[i].enc2});
            chk($sformatf("e%0d vld2", i + 1), {15'd0, ax2.tvalid}, {15'd0, tbl[i].vld2});
            if (i + 1 < 12) begin
                da0 = tbl[i + 1].da0; db0 = tbl[i + 1].db0; da1 = tbl[i + 1].da1;
            end
        end

        // ---- ENC_HALF=3: first word at edge 12, next exactly 12 cycles later ----
        chk("u2 first word", ax2.tdata, 16'hAA55);
        gap = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clkin);
            @(negedge clkin);
            if (ax2.tvalid) begin
                gap = c;
                break;
            end
        end
        chk("u2 tvalid gap", 16'(gap), 16'd12);

        // ---- mid-operation reset while encode=1 ----
        gap = 0;
        for (int c = 0; c < 4; c++) begin
            if (enc0) begin
                gap = 1;
                break;
            end
            @(negedge clkin);
        end
        chk("find encode high", 16'(gap), 16'd1);
        chk("pre-reset ds0", {15'd0, ds0}, 16'd0);
        #3;
        rstn = 1'b0;
        #1;
        chk_reset_state("midreset");
        da0 = 8'h33; db0 = 8'h77;
        repeat (3) @(negedge clkin);
        chk_reset_state("midreset held");
        rstn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clkin);
            @(negedge clkin);
            chk($sformatf("rel e%0d enc0", k), {15'd0, enc0}, {15'd0, k[0]});
            chk($sformatf("rel e%0d vld0", k), {15'd0, ax0.tvalid}, (k == 4) ? 16'd1 : 16'd0);
            chk($sformatf("rel e%0d ds0", k), {15'd0, ds0}, (k == 1) ? 16'd1 : 16'd0);
        end
        chk("rel td0", ax0.tdata, 16'h7733);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_ad9054a

// File: doc/ad9054a.md
# ad9054a

Capture controller for an AD9054A 8-bit ADC. It generates the converter's encode clock and DS sync strobe from the 40 MHz system clock and samples the two 8-bit output buses. Samples are packed into 16-bit words and presented on an AXI-Stream master interface for the downstream FPGA fabric.

## Interface

Parameters:
- `ENC_HALF`, default 1: clkin cycles per encode half-period; encode frequency = clkin / (2·ENC_HALF).
- `DEMUX_MODE`, default 0: value driven on `demux`. 0 selects two-bus interleaved mode; 1 selects single-bus mode (port A only).

Ports:
- `clkin` in 1: system clock, 40 MHz (25 ns). This is the only clock.
- `rstn` in 1: asynchronous, active-low reset.
- `da` in 8: ADC output bus A.
- `db` in 8: ADC output bus B.
- `encode` out 1: ADC encode clock, registered from clkin.
- `encode_b` out 1: complement of `encode`.
- `ds` out 1: ADC data-sync strobe, active high.
- `ds_b` out 1: complement of `ds`.
- `demux` out 1: constant `DEMUX_MODE`.
- `m_axis_aclk` out 1: stream clock, equal to `clkin` (combinational pass-through).
- `m_axis` axistream_if master. Signals:
  - `tdata` [15:0]
  - `tvalid`
  - The interface takes `aclk` as its port.
  - There is no `tready`; the sink must accept every beat.

## Operation

- Reset (rstn=0, asynchronous, immediate):
  - encode=0, encode_b=1.
  - ds=1, ds_b=0.
  - tdata=0, tvalid=0.
  - Divider counter, sample counter and phase bit cleared.
- Encode divider:
  - Counter runs 0..ENC_HALF-1 on clkin.
  - encode toggles when the counter wraps.
  - The first toggle (0→1) occurs ENC_HALF clkin edges after rstn release.
- DS:
  - ds stays high through reset and through the first encode high phase.
  - ds drops on the first encode falling edge, then stays low until the next reset.
  - The ADC aligns its A/B alternation to this strobe.
- Sampling:
  - On each clkin edge where encode falls (1→0), da and db are registered.
  - Data is stable at that point, because the ADC updates on encode rising edges.
  - Sample index n counts from 0, starting at the first falling edge.
- DEMUX_MODE=0 (interleaved):
  - The ADC alternately updates A and B.
  - On odd n (1, 3, 5 …), emit tdata={db,da}: high byte B, low byte A.
  - Even samples are not emitted.
  - The n=0 sample (taken while ds is active) is never emitted.
- DEMUX_MODE=1:
  - Every sample is emitted as tdata={8'h00,da}.
- Stream:
  - tvalid pulses high for exactly one clkin cycle per word.
  - tdata holds its last value until the next word.
- Mid-operation reset: all state is cleared at once and the ds sequence restarts after release. A partially formed pair is discarded.

## Timing

- Latency: tdata and tvalid update on the same clkin edge that samples the buses (the encode falling edge).
- They are visible during the following clkin cycle.
- ENC_HALF=1: encode period 50 ns (20 MHz).
  - DEMUX_MODE=0: one word per 100 ns.
  - DEMUX_MODE=1: one word per 50 ns.
- tvalid duty:
  - DEMUX_MODE=0: 1 cycle in 4·ENC_HALF.
  - DEMUX_MODE=1: 1 cycle in 2·ENC_HALF.
- The sample counter needs only its LSB; it wraps freely with no overflow condition.
- All outputs except m_axis_aclk, encode_b and ds_b come directly from flops. Those three are single-gate derived.

## Test plan

- **Reset values:** hold rstn=0 for 830 ns, clkin=40 MHz.
  - Required throughout: encode=0, encode_b=1, ds=1, ds_b=0, tvalid=0, tdata=0.
- **Encode and DS sequence after release (ENC_HALF=1):**
  - encode rises at the 1st clkin edge after release and falls at the 2nd.
  - encode period is 50 ns; encode_b is always its complement.
  - ds falls at the 2nd edge and stays 0.
- **Interleaved capture (DEMUX_MODE=0):** ADC model starts with da=10, db=15 and alternates A/B updates.
  - Sample n=1 with da=0x12, db=0x1A yields tdata=0x1A12 with a 1-cycle tvalid.
  - Next tvalid comes exactly 4 clkin cycles later.
  - No word is emitted at n=0.
- **Single-bus mode (DEMUX_MODE=1):** da increments each encode.
  - A word arrives every 2 clkin cycles with tdata[15:8]=0x00 and tdata[7:0]=da.
  - demux reads 1.
- **Mid-operation reset:** assert rstn=0 asynchronously between clkin edges while encode=1.
  - encode, tvalid and tdata clear immediately; ds returns to 1.
  - After release, the first word again appears at n=1.
- **Divider parameter (ENC_HALF=3):**
  - encode period is 150 ns.
  - tvalid pulses once per 12 clkin cycles in DEMUX_MODE=0.
